vmu_mem_responder: RTL and testbench

- Responder end of the vector memory request/response interface driven by the vector memory unit.
- Accepts line-granular load and store requests, serves them in order from an internal line-wide memory array, and returns load data tagged with the request ticket after a fixed pipeline latency.
- Stands in for the vector data cache, both in subsystem simulation and as a scratchpad-style backing store.

---
 rtl/vmu_mem_responder_if.sv | 35 +++
 rtl/vmu_mem_responder.sv | 145 ++++++++++++++
 tb/tb_vmu_mem_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vmu_mem_responder_if.sv
// Request/response bus between the vector memory unit (master) and its memory responder (slave).
interface vmu_mem_responder_if #(
    parameter int unsigned REQ_DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MICROOP_WIDTH  = 5,
    parameter int unsigned TICKET_WIDTH   = 6
);
    localparam int unsigned SIZE_WIDTH = $clog2(REQ_DATA_WIDTH / 8) + 1;

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [ADDR_WIDTH-1:0]     req_addr_i;
    logic [MICROOP_WIDTH-1:0]  req_microop_i;
    logic [SIZE_WIDTH-1:0]     req_size_i;
    logic [TICKET_WIDTH-1:0]   req_ticket_i;
    logic [REQ_DATA_WIDTH-1:0] req_data_i;
    logic                      stall_i;
    logic                      resp_valid_o;
    logic [TICKET_WIDTH-1:0]   resp_ticket_o;
    logic [SIZE_WIDTH-1:0]     resp_size_o;
    logic [REQ_DATA_WIDTH-1:0] resp_data_o;
    logic                      idle_o;

    modport master (
        output req_valid_i, req_addr_i, req_microop_i, req_size_i, req_ticket_i, req_data_i,
        output stall_i,
        input  req_ready_o, resp_valid_o, resp_ticket_o, resp_size_o, resp_data_o, idle_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_microop_i, req_size_i, req_ticket_i, req_data_i,
        input  stall_i,
        output req_ready_o, resp_valid_o, resp_ticket_o, resp_size_o, resp_data_o, idle_o
    );
endinterface

// File: rtl/vmu_mem_responder.sv
// Line-wide memory responder: in-order request queue, byte-granular stores and a fixed-latency
// load response pipeline. The memory array is intentionally not reset.
module vmu_mem_responder #(
    parameter int unsigned REQ_DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MICROOP_WIDTH  = 5,
    parameter int unsigned TICKET_WIDTH   = 6,
    parameter int unsigned LINES          = 64,
    parameter int unsigned LATENCY        = 2,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input logic              clk,
    input logic              rst,
    vmu_mem_responder_if.slave bus
);
    localparam int unsigned LINE_BYTES = REQ_DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W      = $clog2(LINES);
    localparam int unsigned SIZE_W     = OFF_W + 1;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [MICROOP_WIDTH-1:0]  microop;
        logic [SIZE_W-1:0]         size;
        logic [TICKET_WIDTH-1:0]   ticket;
        logic [REQ_DATA_WIDTH-1:0] data;
    } req_t;

    req_t              fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [REQ_DATA_WIDTH-1:0] mem_q [LINES];

    logic [LATENCY-1:0]        pipe_valid_q, pipe_valid_d;
    logic [TICKET_WIDTH-1:0]   pipe_ticket_q [LATENCY];
    logic [TICKET_WIDTH-1:0]   pipe_ticket_d [LATENCY];
    logic [SIZE_W-1:0]         pipe_size_q [LATENCY];
    logic [SIZE_W-1:0]         pipe_size_d [LATENCY];
    logic [REQ_DATA_WIDTH-1:0] pipe_data_q [LATENCY];
    logic [REQ_DATA_WIDTH-1:0] pipe_data_d [LATENCY];

    logic                      push, issue, is_load, is_store;
    req_t                      head;
    logic [OFF_W-1:0]          off;
    logic [IDX_W-1:0]          idx;
    logic [REQ_DATA_WIDTH-1:0] line_rd, mem_line_d, ld_shift, ld_data;

    // Ready looks only at the registered count, so a full queue never accepts on a pop cycle.
    assign bus.req_ready_o = (count_q < CNT_W'(FIFO_DEPTH));
    assign push            = bus.req_valid_i & bus.req_ready_o;
    assign issue           = (count_q != '0) & ~bus.stall_i;

    assign head     = fifo_q[rd_ptr_q];
    assign off      = head.addr[OFF_W-1:0];
    assign idx      = head.addr[OFF_W+IDX_W-1:OFF_W];
    assign is_load  = (head.microop == MICROOP_WIDTH'(0));
    assign is_store = (head.microop == MICROOP_WIDTH'(4));
    assign line_rd  = mem_q[idx];
    assign ld_shift = line_rd >> {off, 3'b000};

    always_comb begin
        mem_line_d = line_rd;
        ld_data    = '0;
        for (int j = 0; j < int'(LINE_BYTES); j++) begin
            // Destination byte j takes source byte j-off; bytes past the line end never land.
            if (j >= int'(off) && (j - int'(off)) < int'(head.size)) begin
                mem_line_d[8*j +: 8] = head.data[8*(j - int'(off)) +: 8];
            end
            if (j < int'(head.size)) begin
                ld_data[8*j +: 8] = ld_shift[8*j +: 8];
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(issue);
        count_d  = count_q + CNT_W'(push) - CNT_W'(issue);
    end

    // Payload stages only advance behind a valid, so resp_* hold the last response.
    always_comb begin
        pipe_valid_d[0]  = issue & is_load;
        pipe_ticket_d[0] = (issue & is_load) ? head.ticket : pipe_ticket_q[0];
        pipe_size_d[0]   = (issue & is_load) ? head.size   : pipe_size_q[0];
        pipe_data_d[0]   = (issue & is_load) ? ld_data     : pipe_data_q[0];
        for (int k = 1; k < int'(LATENCY); k++) begin
            pipe_valid_d[k]  = pipe_valid_q[k-1];
            pipe_ticket_d[k] = pipe_valid_q[k-1] ? pipe_ticket_q[k-1] : pipe_ticket_q[k];
            pipe_size_d[k]   = pipe_valid_q[k-1] ? pipe_size_q[k-1]   : pipe_size_q[k];
            pipe_data_d[k]   = pipe_valid_q[k-1] ? pipe_data_q[k-1]   : pipe_data_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pipe_valid_q <= '0;
            for (int k = 0; k < int'(LATENCY); k++) begin
                pipe_ticket_q[k] <= '0;
                pipe_size_q[k]   <= '0;
                pipe_data_q[k]   <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pipe_valid_q <= pipe_valid_d;
            for (int k = 0; k < int'(LATENCY); k++) begin
                pipe_ticket_q[k] <= pipe_ticket_d[k];
                pipe_size_q[k]   <= pipe_size_d[k];
                pipe_data_q[k]   <= pipe_data_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr:    bus.req_addr_i,
                                  microop: bus.req_microop_i,
                                  size:    bus.req_size_i,
                                  ticket:  bus.req_ticket_i,
                                  data:    bus.req_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (issue && is_store) begin
            mem_q[idx] <= mem_line_d;
        end
    end

    assign bus.resp_valid_o  = pipe_valid_q[LATENCY-1];
    assign bus.resp_ticket_o = pipe_ticket_q[LATENCY-1];
    assign bus.resp_size_o   = pipe_size_q[LATENCY-1];
    assign bus.resp_data_o   = pipe_data_q[LATENCY-1];
    assign bus.idle_o        = (count_q == '0) & ~|pipe_valid_q;

endmodule

// File: tb/tb_vmu_mem_responder.sv
// Randomized and directed bench for vmu_mem_responder against a byte-array / queue reference.
module tb_vmu_mem_responder;
    localparam int LB      = 32;
    localparam int LINES   = 64;
    localparam int LAT     = 2;
    localparam int DEPTH   = 4;

    typedef struct {
        logic [31:0]  addr;
        logic [4:0]   op;
        int           size;
        logic [5:0]   ticket;
        logic [255:0] data;
    } mreq_t;

    typedef struct {
        int           due;
        logic [5:0]   ticket;
        int           size;
        logic [255:0] data;
    } mresp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vmu_mem_responder_if bus ();

    vmu_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]   mem [LINES*LB];
    mreq_t        q[$];
    mresp_t       exp_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_err = 0;
    bit           accepted;
    logic [5:0]   last_ticket = '0;
    logic [5:0]   last_size = '0;
    logic [255:0] last_data = '0;
    logic [255:0] obs_data;
    logic [5:0]   obs_tickets[$];

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_issue(input mreq_t r);
        int idx = int'((r.addr / LB) % LINES);
        int off = int'(r.addr % LB);
        mresp_t e;
        if (r.op == 5'd0) begin
            e.due = cyc + LAT;
            e.ticket = r.ticket;
            e.size = r.size;
            e.data = '0;
            for (int i = 0; i < r.size; i++)
                if (off + i < LB) e.data[8*i +: 8] = mem[idx*LB + off + i];
            exp_q.push_back(e);
        end else if (r.op == 5'd4) begin
            for (int i = 0; i < r.size; i++)
                if (off + i < LB) mem[idx*LB + off + i] = r.data[8*i +: 8];
        end
    endtask

    // Called mid-cycle: compares outputs for this cycle, then advances the model over the edge.
    task automatic model_step();
        bit ready_m = (q.size() < DEPTH);
        mreq_t r;
        check_eq("req_ready", bus.req_ready_o, ready_m);
        check_eq("idle", bus.idle_o, (q.size() == 0) && (exp_q.size() == 0));
        if (bus.resp_valid_o === 1'b1) begin
            obs_data = bus.resp_data_o;
            obs_tickets.push_back(bus.resp_ticket_o);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check_eq("resp_valid", bus.resp_valid_o, 1);
            check_eq("resp_ticket", bus.resp_ticket_o, exp_q[0].ticket);
            check_eq("resp_size", bus.resp_size_o, exp_q[0].size);
            check_eq("resp_data", bus.resp_data_o, exp_q[0].data);
            last_ticket = exp_q[0].ticket;
            last_size = 6'(exp_q[0].size);
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end else begin
            check_eq("resp_valid_idle", bus.resp_valid_o, 0);
            check_eq("resp_hold", {bus.resp_ticket_o, bus.resp_size_o, bus.resp_data_o[31:0]},
                     {last_ticket, last_size, last_data[31:0]});
        end
        if (q.size() > 0 && bus.stall_i == 1'b0) model_issue(q.pop_front());
        accepted = bus.req_valid_i && ready_m;
        if (accepted) begin
            r.addr = bus.req_addr_i;
            r.op = bus.req_microop_i;
            r.size = int'(bus.req_size_i);
            r.ticket = bus.req_ticket_i;
            r.data = bus.req_data_i;
            q.push_back(r);
        end
        cyc++;
    endtask

    task automatic drive(input bit v, input logic [4:0] op, input logic [31:0] a, input int sz,
                         input logic [5:0] t, input logic [255:0] d, input bit st);
        @(posedge clk);
        #1;
        bus.req_valid_i = v;
        bus.req_microop_i = op;
        bus.req_addr_i = a;
        bus.req_size_i = 6'(sz);
        bus.req_ticket_i = t;
        bus.req_data_i = d;
        bus.stall_i = st;
        @(negedge clk);
        model_step();
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input int sz,
                        input logic [5:0] t, input logic [255:0] d, input bit st);
        accepted = 1'b0;
        for (int n = 0; n < 40 && !accepted; n++) drive(1'b1, op, a, sz, t, d, st);
        check_eq("send_bound", accepted, 1);
    endtask

    task automatic idle_cycles(input int n, input bit st);
        for (int k = 0; k < n; k++) drive(1'b0, 5'd0, 32'd0, 0, 6'd0, '0, st);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        #1;
        check_eq("rst_valid", bus.resp_valid_o, 0);
        check_eq("rst_ready", bus.req_ready_o, 1);
        check_eq("rst_idle", bus.idle_o, 1);
        check_eq("rst_fields", {bus.resp_ticket_o, bus.resp_size_o, bus.resp_data_o}, '0);
        q.delete();
        exp_q.delete();
        last_ticket = '0;
        last_size = '0;
        last_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        model_step();
    endtask

    initial begin
        logic [255:0] pat;
        logic [255:0] d;
        bus.req_valid_i = 1'b0;
        bus.req_microop_i = '0;
        bus.req_addr_i = '0;
        bus.req_size_i = '0;
        bus.req_ticket_i = '0;
        bus.req_data_i = '0;
        bus.stall_i = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_eq("init_valid", bus.resp_valid_o, 0);
        check_eq("init_ready", bus.req_ready_o, 1);
        check_eq("init_idle", bus.idle_o, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int l = 0; l < LINES; l++) send(5'd4, 32'(l * LB), LB, 6'd0, rand_line(), 1'b0);
        idle_cycles(4, 1'b0);

        // Store then load of a full line.
        for (int i = 0; i < LB; i++) pat[8*i +: 8] = 8'(i);
        send(5'd4, 32'h40, 32, 6'd0, pat, 1'b0);
        send(5'd0, 32'h40, 32, 6'd5, '0, 1'b0);
        idle_cycles(4, 1'b0);
        check_eq("full_line_data", obs_data, pat);

        // Unaligned partial store and loads.
        send(5'd4, 32'h84, 8, 6'd0, 256'h1122334455667788, 1'b0);
        send(5'd0, 32'h86, 4, 6'd6, '0, 1'b0);
        idle_cycles(4, 1'b0);
        check_eq("unaligned_data", obs_data, 256'h33445566);
        send(5'd0, 32'h1E, 8, 6'd7, '0, 1'b0);
        idle_cycles(4, 1'b0);
        check_eq("line_end_zero", obs_data[255:16], '0);

        // Backpressure: four fill the queue under stall, fifth waits.
        obs_tickets.delete();
        for (int k = 0; k < 4; k++) send(5'd0, 32'(k * 64), 32, 6'(10 + k), '0, 1'b1);
        drive(1'b1, 5'd0, 32'h100, 32, 6'd14, '0, 1'b1);
        check_eq("full_not_ready", bus.req_ready_o, 0);
        send(5'd0, 32'h100, 32, 6'd14, '0, 1'b0);
        idle_cycles(8, 1'b0);
        check_eq("bp_count", obs_tickets.size(), 5);
        for (int k = 0; k < 5 && k < obs_tickets.size(); k++)
            check_eq("bp_order", obs_tickets[k], 10 + k);

        // Aliasing and illegal microop.
        d = rand_line();
        send(5'd4, 32'h0, 32, 6'd0, d, 1'b0);
        send(5'd0, 32'(LINES * LB), 32, 6'd20, '0, 1'b0);
        idle_cycles(4, 1'b0);
        check_eq("alias_data", obs_data, d);
        obs_tickets.delete();
        send(5'd1, 32'h0, 32, 6'd21, '0, 1'b0);
        idle_cycles(4, 1'b0);
        check_eq("illegal_no_resp", obs_tickets.size(), 0);
        check_eq("illegal_idle", bus.idle_o, 1);

        // Stall raised behind an in-flight load.
        send(5'd0, 32'h40, 16, 6'd22, '0, 1'b0);
        idle_cycles(1, 1'b0);
        send(5'd0, 32'h80, 16, 6'd23, '0, 1'b1);
        idle_cycles(5, 1'b1);
        idle_cycles(5, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 99);
            logic [4:0] op = (r < 45) ? 5'd0 : (r < 90) ? 5'd4 : 5'($urandom_range(1, 31));
            drive($urandom_range(0, 9) < 7, op, $urandom, $urandom_range(0, LB),
                  6'($urandom), rand_line(), $urandom_range(0, 3) == 0);
        end
        idle_cycles(10, 1'b0);

        // Reset with loads in flight; stored data survives.
        d = rand_line();
        send(5'd4, 32'h200, 32, 6'd0, d, 1'b0);
        idle_cycles(2, 1'b0);
        for (int k = 0; k < 3; k++) send(5'd0, 32'h200, 32, 6'(30 + k), '0, 1'b0);
        obs_tickets.delete();
        do_reset();
        idle_cycles(6, 1'b0);
        check_eq("rst_no_resp", obs_tickets.size(), 0);
        send(5'd0, 32'h200, 32, 6'd40, '0, 1'b0);
        idle_cycles(4, 1'b0);
        check_eq("rst_mem_kept", obs_data, d);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
